// File: rtl/MIPS_pkg.sv
// Shared MIPS core types: data width, HI/LO pair, and multiply/divide unit encodings.
package MIPS_pkg;

  localparam int MIPS_DATA_WIDTH = 32;

  typedef logic [MIPS_DATA_WIDTH-1:0] mips_data_t;

  typedef struct packed {
    mips_data_t hi;
    mips_data_t lo;
  } mips_hilo_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Control-FSM side bundle of the multiply/divide unit: launch, MTHI/MTLO write path and HI/LO results.
interface mips_muldiv_unit_if
  import MIPS_pkg::*;
#(
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH
);
  logic                  start_i;
  muldiv_op_t            op_i;
  logic [DATA_WIDTH-1:0] rs_i;
  logic [DATA_WIDTH-1:0] rt_i;
  logic                  mthi_i;
  logic                  mtlo_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  div_by_zero_o;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/mips_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module mips_cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = neg_i ? (~x_i + {{(WIDTH-1){1'b0}}, 1'b1}) : x_i;
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or restoring-divide step per cycle
// on operand magnitudes, with sign fix-up applied in a final cycle.
module mips_muldiv_unit
  import MIPS_pkg::*;
#(
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  mips_muldiv_unit_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  muldiv_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic busy_q, done_q, dbz_q, is_div_q, zdiv_q;
  logic [W-1:0] hi_q, lo_q;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   a_q;
  logic           neg_q, rneg_q;

  logic         signed_op, rs_neg, rt_neg, start_go, start_div, start_zdiv;
  logic [W-1:0] rs_abs, rt_abs;
  logic [W:0]   step_sum, shifted, diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  assign signed_op  = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  assign rs_neg     = signed_op & bus.rs_i[W-1];
  assign rt_neg     = signed_op & bus.rt_i[W-1];
  assign start_go   = (state_q == MD_IDLE) && bus.start_i;
  assign start_div  = bus.op_i[1];
  assign start_zdiv = start_div && (bus.rt_i == '0);

  mips_cond_negate #(.WIDTH(W))   u_abs_rs   (.neg_i(rs_neg), .x_i(bus.rs_i), .y_o(rs_abs));
  mips_cond_negate #(.WIDTH(W))   u_abs_rt   (.neg_i(rt_neg), .x_i(bus.rt_i), .y_o(rt_abs));
  mips_cond_negate #(.WIDTH(2*W)) u_fix_prod (.neg_i(neg_q),  .x_i(acc_q),    .y_o(prod_fix));
  mips_cond_negate #(.WIDTH(W))   u_fix_quo  (.neg_i(neg_q),  .x_i(acc_q[W-1:0]),   .y_o(quo_fix));
  mips_cond_negate #(.WIDTH(W))   u_fix_rem  (.neg_i(rneg_q), .x_i(acc_q[2*W-1:W]), .y_o(rem_fix));

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    step_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    shifted  = acc_q[2*W-1:W-1];
    diff     = shifted - {1'b0, a_q};
    if (!is_div_q)
      acc_d = {step_sum, acc_q[W-1:1]};
    else if (!diff[W])
      acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    else
      acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (start_go) begin
      // divide-by-zero keeps raw rs so FIX can copy it to HI unchanged
      acc_q  <= {{W{1'b0}}, start_zdiv ? bus.rs_i : (start_div ? rs_abs : rt_abs)};
      a_q    <= start_div ? rt_abs : rs_abs;
      neg_q  <= rs_neg ^ rt_neg;
      rneg_q <= rs_neg;
    end else if (state_q == MD_CALC) begin
      acc_q  <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (bus.start_i) begin
            is_div_q <= start_div;
            zdiv_q   <= start_zdiv;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(DATA_WIDTH - 1);
            state_q  <= start_zdiv ? MD_FIX : MD_CALC;
          end else begin
            if (bus.mthi_i) hi_q <= bus.wdata_i;
            if (bus.mtlo_i) lo_q <= bus.wdata_i;
          end
        end
        MD_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= MD_FIX;
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (zdiv_q) begin
            hi_q  <= acc_q[W-1:0];
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mips_muldiv_unit;
  import MIPS_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mips_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  mips_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result computed directly from MIPS semantics with wide arithmetic.
  task automatic model(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    dbz = 1'b0;
    sa = $signed({{32{rs[W-1]}}, rs});
    sb = $signed({{32{rt[W-1]}}, rt});
    case (op)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'b0, rs} * {32'b0, rt}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (rt == '0) begin
          hi = rs; lo = '1; dbz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = rs % rt; lo = rs / rt;
        end
      end
    endcase
  endtask

  // mode 0: plain; 1: start/MTHI/MTLO while busy; 2: MTHI/MTLO in the start cycle
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input int mode, input string tag);
    logic [W-1:0] ehi, elo;
    logic edbz;
    int k, elat;
    model(op, rs, rt, ehi, elo, edbz);
    elat = edbz ? 2 : W + 2;
    bus.op_i = muldiv_op_t'(op);
    bus.rs_i = rs;
    bus.rt_i = rt;
    bus.start_i = 1'b1;
    if (mode == 2) begin
      bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.wdata_i = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    k = 1;
    chk({tag, ".busy1"}, 64'(bus.busy_o), 64'd1);
    chk({tag, ".hold1"}, {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
    while (!bus.done_o && k < 80) begin
      if (mode == 1 && k == 5) begin
        bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.rs_i = $urandom; bus.rt_i = $urandom;
        bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.wdata_i = 32'h5555_AAAA;
      end
      if (k == W && !edbz) chk({tag, ".holdW"}, {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
      @(posedge clk); #1;
      k++;
      bus.start_i = 1'b0; bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    end
    chk({tag, ".lat"}, 64'(k), 64'(elat));
    chk({tag, ".busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, ".dbz"}, 64'(bus.div_by_zero_o), 64'(edbz));
    chk({tag, ".hilo"}, {bus.hi_o, bus.lo_o}, {ehi, elo});
    model_hi = ehi;
    model_lo = elo;
  endtask

  task automatic mt_write(input logic hi_en, input logic lo_en, input logic [W-1:0] v);
    bus.mthi_i = hi_en; bus.mtlo_i = lo_en; bus.wdata_i = v;
    @(posedge clk); #1;
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    if (hi_en) model_hi = v;
    if (lo_en) model_lo = v;
    chk("mt.hilo", {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    bus.start_i = 1'b0; bus.op_i = OP_MULT; bus.rs_i = '0; bus.rt_i = '0;
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0; bus.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.busy_o), 64'd0);
    chk("rst.done", 64'(bus.done_o), 64'd0);
    chk("rst.dbz", 64'(bus.div_by_zero_o), 64'd0);
    chk("rst.hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, "mult");
    run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, "multu");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div");
    run_op(2'd3, 32'h0000_0007, 32'h0000_0002, 0, "divu");
    run_op(2'd3, 32'h0000_0007, 32'h0000_0000, 0, "divu0");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divovf");
    run_op(2'd2, 32'h0000_0009, 32'h0000_0000, 0, "div0");
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    mt_write(1'b0, 1'b1, 32'hCAFE_0001);
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    run_op(2'd0, 32'h0000_1234, 32'hFFFF_0003, 1, "busyign");
    run_op(2'd3, 32'h0001_0000, 32'h0000_0013, 2, "startwins");

    bus.op_i = OP_MULT; bus.rs_i = 32'h7FFF_FFFF; bus.rt_i = 32'h0000_0123; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    model_hi = '0; model_lo = '0;
    chk("midrst.busy", 64'(bus.busy_o), 64'd0);
    chk("midrst.done", 64'(bus.done_o), 64'd0);
    chk("midrst.dbz", 64'(bus.div_by_zero_o), 64'd0);
    chk("midrst.hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) seen = 1;
    end
    chk("midrst.quiet", 64'(seen), 64'd0);
    run_op(2'd0, 32'd3, 32'd5, 0, "mult3x5");

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
